// File: rtl/nios_system_sram_pkg.sv
// Shared types and widths for the SRAM PIO controller.
package nios_system_sram_pkg;
    localparam int SRAM_ADDR_W = 11;
    localparam int SRAM_DATA_W = 16;
    localparam int WAIT_CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        HOLD   = 2'd3
    } sram_state_t;
endpackage

// File: rtl/nios_system_sram_ctrl_if.sv
// Asynchronous SRAM pin bundle; master is the controller, slave is the device side.
interface nios_system_sram_ctrl_if
    import nios_system_sram_pkg::*;
#(
    parameter int ADDR_W = SRAM_ADDR_W,
    parameter int DATA_W = SRAM_DATA_W
);
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_dq_o;
    logic              sram_dq_oe;
    logic [DATA_W-1:0] sram_dq_i;
    logic              sram_ce_n;
    logic              sram_oe_n;
    logic              sram_we_n;

    modport master (
        output sram_addr, sram_dq_o, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n,
        input  sram_dq_i
    );
    modport slave (
        input  sram_addr, sram_dq_o, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n,
        output sram_dq_i
    );
endinterface

// File: rtl/nios_system_sram_edge_det.sv
// Registered rising-edge detector for a PIO request level.
module nios_system_sram_edge_det (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic rise
);
    logic d_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) d_q <= 1'b0;
        else          d_q <= d;
    end

    assign rise = d & ~d_q;
endmodule

// File: rtl/nios_system_sram_ctrl.sv
// PIO-driven asynchronous SRAM controller: SETUP / ACCESS (WAIT_STATES+1) / HOLD cycles.
// Optional macro SRAM_CTRL_AUTOINC_EN replaces addr_in with a post-incrementing pointer.
module nios_system_sram_ctrl
    import nios_system_sram_pkg::*;
#(
    parameter int ADDR_W      = SRAM_ADDR_W,
    parameter int DATA_W      = SRAM_DATA_W,
    parameter int WAIT_STATES = 2
)(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] wdata_in,
    input  logic              start_rd,
    input  logic              start_wr,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    nios_system_sram_ctrl_if.master sram
);
    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_SETUP  = SETUP;
    localparam logic [1:0] ST_ACCESS = ACCESS;
    localparam logic [1:0] ST_HOLD   = HOLD;
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_STATES);

    logic                  rd_rise, wr_rise;
    logic [1:0]            state;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic                  is_wr;
    logic [ADDR_W-1:0]     acc_addr;

    nios_system_sram_edge_det u_rd_edge (.clk(clk), .reset_n(reset_n), .d(start_rd), .rise(rd_rise));
    nios_system_sram_edge_det u_wr_edge (.clk(clk), .reset_n(reset_n), .d(start_wr), .rise(wr_rise));

`ifdef SRAM_CTRL_AUTOINC_EN
    logic [ADDR_W-1:0] ptr, addr_q;

    // A fresh software address takes priority over the post-increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr    <= '0;
            addr_q <= '0;
        end else begin
            addr_q <= addr_in;
            if (addr_in != addr_q)   ptr <= addr_in;
            else if (state == ST_HOLD) ptr <= ptr + 1'b1;
        end
    end

    assign acc_addr = ptr;
`else
    assign acc_addr = addr_in;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            wait_cnt       <= '0;
            is_wr          <= 1'b0;
            sram.sram_addr <= '0;
            sram.sram_dq_o <= '0;
            sram.sram_dq_oe <= 1'b0;
            sram.sram_ce_n <= 1'b1;
            sram.sram_oe_n <= 1'b1;
            sram.sram_we_n <= 1'b1;
            rd_data        <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Write wins a same-cycle collision; edges seen while busy are lost.
                    if (wr_rise || rd_rise) begin
                        state          <= ST_SETUP;
                        is_wr          <= wr_rise;
                        sram.sram_addr <= acc_addr;
                        sram.sram_ce_n <= 1'b0;
                        busy           <= 1'b1;
                        if (wr_rise) begin
                            sram.sram_dq_o  <= wdata_in;
                            sram.sram_dq_oe <= 1'b1;
                        end
                    end
                end
                ST_SETUP: begin
                    state    <= ST_ACCESS;
                    wait_cnt <= WAIT_LOAD;
                    if (is_wr) sram.sram_we_n <= 1'b0;
                    else       sram.sram_oe_n <= 1'b0;
                end
                ST_ACCESS: begin
                    if (wait_cnt == '0) begin
                        state          <= ST_HOLD;
                        sram.sram_we_n <= 1'b1;
                        sram.sram_oe_n <= 1'b1;
                        if (!is_wr) rd_data <= sram.sram_dq_i;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                ST_HOLD: begin
                    state           <= ST_IDLE;
                    sram.sram_ce_n  <= 1'b1;
                    sram.sram_dq_oe <= 1'b0;
                    busy            <= 1'b0;
                    done            <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nios_system_sram_ctrl.sv
// Randomized + directed bench for nios_system_sram_ctrl against a per-transaction timeline model.
module tb_nios_system_sram_ctrl;
    localparam int AW = 11;
    localparam int DW = 16;
    localparam int W  = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [AW-1:0] addr_in = '0;
    logic [DW-1:0] wdata_in = '0;
    logic          start_rd = 1'b0;
    logic          start_wr = 1'b0;
    logic [DW-1:0] rd_data;
    logic          busy, done;
    logic [DW-1:0] noise = '0;
    logic [DW-1:0] mem [0:(1<<AW)-1];

    always #5 clk = ~clk;

    nios_system_sram_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) sram_bus ();

    // Device model: drives stored data only while selected and output-enabled.
    assign sram_bus.sram_dq_i = (!sram_bus.sram_ce_n && !sram_bus.sram_oe_n) ?
                                mem[sram_bus.sram_addr] : noise;

    nios_system_sram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(W)) dut (
        .clk(clk), .reset_n(reset_n), .addr_in(addr_in), .wdata_in(wdata_in),
        .start_rd(start_rd), .start_wr(start_wr), .rd_data(rd_data),
        .busy(busy), .done(done), .sram(sram_bus)
    );

    int n_tests = 0, n_fail = 0;
    int cyc = 0, t0 = 0, done_cyc = -1;
    int we_lo = 0, oe_lo = 0, n_done = 0, oe_hi = 0;
    bit act, m_wr, done_now, prev_rd, prev_wr;
    logic [AW-1:0] e_addr, ptr, aq;
    logic [DW-1:0] e_dq, e_rd;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        act = 0; done_now = 0; prev_rd = 0; prev_wr = 0;
        e_addr = '0; e_dq = '0; e_rd = '0; ptr = '0; aq = '0;
    endtask

    task automatic check_outputs();
        int  k = cyc - t0;
        bit  acc = act && k >= 1 && k <= W + 1;
        chk("busy",    busy,                 act);
        chk("done",    done,                 done_now);
        chk("ce_n",    sram_bus.sram_ce_n,   !act);
        chk("we_n",    sram_bus.sram_we_n,   !(acc && m_wr));
        chk("oe_n",    sram_bus.sram_oe_n,   !(acc && !m_wr));
        chk("dq_oe",   sram_bus.sram_dq_oe,  act && m_wr);
        chk("addr",    sram_bus.sram_addr,   e_addr);
        chk("dq_o",    sram_bus.sram_dq_o,   e_dq);
        chk("rd_data", rd_data,              e_rd);
    endtask

    // One clock: advance the model at the edge, check at the following falling edge.
    task automatic cycle();
        bit rr, rw, can;
        int k;
        @(posedge clk);
        cyc++;
        if (!reset_n) begin
            model_reset();
        end else begin
            rr = start_rd && !prev_rd;
            rw = start_wr && !prev_wr;
            prev_rd = start_rd; prev_wr = start_wr;
            can = !act;
            done_now = 0;
            if (act) begin
                k = cyc - t0;
                if (k == W + 2 && !m_wr) e_rd = mem[e_addr];
                if (k == W + 3) begin act = 0; done_now = 1; end
            end
            if (can && (rr || rw)) begin
                act = 1; t0 = cyc; m_wr = rw;
`ifdef SRAM_CTRL_AUTOINC_EN
                e_addr = ptr;
`else
                e_addr = addr_in;
`endif
                if (rw) begin e_dq = wdata_in; mem[e_addr] = wdata_in; end
            end
`ifdef SRAM_CTRL_AUTOINC_EN
            if (addr_in != aq) ptr = addr_in;
            else if (done_now) ptr = ptr + 1'b1;
            aq = addr_in;
`endif
        end
        @(negedge clk);
        check_outputs();
        if (!sram_bus.sram_we_n) we_lo++;
        if (!sram_bus.sram_oe_n) oe_lo++;
        if (sram_bus.sram_dq_oe) oe_hi++;
        if (done) begin n_done++; done_cyc = cyc; end
        noise = DW'($urandom);
    endtask

    task automatic do_acc(bit wr, bit rd, logic [AW-1:0] a, logic [DW-1:0] d,
                          output logic [AW-1:0] seen);
        int c0;
        addr_in = a; wdata_in = d; start_wr = wr; start_rd = rd;
        done_cyc = -1;
        cycle();
        c0 = cyc;
        seen = sram_bus.sram_addr;
        start_wr = 0; start_rd = 0;
        repeat (W + 5) cycle();
        chk("latency", done_cyc - c0, W + 3);
    endtask

    initial begin
        logic [AW-1:0] seen;
        logic [AW-1:0] exp_ai [3];
        int we0, oe0, d0, h0;

        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
        model_reset();

        // Reset held with random inputs
        for (int i = 0; i < 6; i++) begin
            addr_in = AW'($urandom); wdata_in = DW'($urandom);
            start_rd = 1'($urandom); start_wr = 1'($urandom);
            cycle();
        end
        start_rd = 0; start_wr = 0;
        cycle();
        reset_n = 1;
        repeat (2) cycle();

        // Write 0xBEEF @ 0x2A5
        we0 = we_lo;
        do_acc(1, 0, 11'h2A5, 16'hBEEF, seen);
        chk("wr_addr", seen, 11'h2A5);
        chk("we_len", we_lo - we0, 3);

        // Read back
        oe0 = oe_lo; h0 = oe_hi;
        do_acc(0, 1, 11'h2A5, 16'h0000, seen);
        chk("rdback", rd_data, 16'hBEEF);
        chk("oe_len", oe_lo - oe0, 3);
        chk("rd_dq_oe", oe_hi - h0, 0);

        // Same-cycle collision: write only
        we0 = we_lo; oe0 = oe_lo; d0 = n_done;
        do_acc(1, 1, 11'h155, 16'h1234, seen);
        chk("col_done", n_done - d0, 1);
        chk("col_we", we_lo - we0, 3);
        chk("col_oe", oe_lo - oe0, 0);

        // Second edge while busy is dropped
        d0 = n_done; we0 = we_lo;
        addr_in = 11'h0F0; wdata_in = 16'hA5A5;
        start_wr = 1; cycle(); start_wr = 0; cycle();
        start_wr = 1; cycle(); start_wr = 0;
        repeat (W + 6) cycle();
        chk("busy_done", n_done - d0, 1);
        chk("busy_we", we_lo - we0, 3);

        // Reset during ACCESS
        d0 = n_done;
        addr_in = 11'h321; wdata_in = 16'h7777; start_wr = 1; cycle(); start_wr = 0;
        repeat (2) cycle();
        chk("pre_rst_we", sram_bus.sram_we_n, 0);
        #2 reset_n = 0;
        #1;
        chk("rst_ce", sram_bus.sram_ce_n, 1);
        chk("rst_we", sram_bus.sram_we_n, 1);
        chk("rst_oe", sram_bus.sram_oe_n, 1);
        chk("rst_busy", busy, 0);
        model_reset();
        repeat (2) cycle();
        reset_n = 1;
        repeat (6) cycle();
        chk("rst_nodone", n_done - d0, 0);
        do_acc(0, 1, 11'h2A5, 16'h0000, seen);
        chk("post_rst_rd", rd_data, 16'hBEEF);

        // Address pointer behaviour at the top of the address space
`ifdef SRAM_CTRL_AUTOINC_EN
        exp_ai[0] = 11'h7FE; exp_ai[1] = 11'h7FF; exp_ai[2] = 11'h000;
`else
        exp_ai[0] = 11'h7FE; exp_ai[1] = 11'h7FE; exp_ai[2] = 11'h7FE;
`endif
        addr_in = 11'h000; cycle();
        addr_in = 11'h7FE; repeat (2) cycle();
        for (int i = 0; i < 3; i++) begin
            do_acc(1, 0, 11'h7FE, DW'($urandom), seen);
            chk("autoinc", seen, exp_ai[i]);
        end

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) start_wr = ~start_wr;
            if ($urandom_range(0, 3) == 0) start_rd = ~start_rd;
            if ($urandom_range(0, 7) == 0)
                addr_in = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            wdata_in = DW'($urandom);
            cycle();
        end
        start_wr = 0; start_rd = 0;
        repeat (W + 6) cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
